// File: rtl/ex_muldiv.sv
// Iterative RV32M multiply/divide unit for the EX stage: radix-2 shift-add multiply,
// restoring divide, with a stall request that holds ID/EX while a result is computed.
module ex_muldiv #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             rdy_in,
    input  logic             start_in,
    input  logic [2:0]       funct3_in,
    input  logic [WIDTH-1:0] rs1_in,
    input  logic [WIDTH-1:0] rs2_in,
    input  logic [4:0]       rd_in,
    output logic             stall_req_out,
    output logic             done_out,
    output logic [WIDTH-1:0] result_out,
    output logic [4:0]       rd_out
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_t;

    state_t             r_state;
    logic [CW-1:0]      r_count;
    logic [2:0]         r_funct3;
    logic [4:0]         r_rd;
    logic               r_neg;
    logic [WIDTH-1:0]   r_opd;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_result;

    logic               w_is_div;
    logic               w_a_signed;
    logic               w_b_signed;
    logic               w_a_neg;
    logic               w_b_neg;
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic               w_neg_start;
    logic               w_div_zero;
    logic               w_div_ovf;
    logic [WIDTH-1:0]   w_special_res;

    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_shift;
    logic [WIDTH:0]     w_diff;
    logic [2*WIDTH-1:0] w_acc_nxt;
    logic [2*WIDTH-1:0] w_prod_s;
    logic [WIDTH-1:0]   w_quot;
    logic [WIDTH-1:0]   w_rem;
    logic [WIDTH-1:0]   w_final;

    assign stall_req_out = ((r_state == S_IDLE) && start_in) || (r_state == S_CALC);
    assign done_out      = (r_state == S_DONE);
    assign result_out    = r_result;
    assign rd_out        = r_rd;

    // Operand decode at acceptance: magnitudes, sign of the final result, special divides.
    always_comb begin
        w_is_div   = funct3_in[2];
        w_a_signed = w_is_div ? ~funct3_in[0] : (funct3_in[1:0] == 2'b01 || funct3_in[1:0] == 2'b10);
        w_b_signed = w_is_div ? ~funct3_in[0] : (funct3_in[1:0] == 2'b01);
        w_a_neg    = w_a_signed & rs1_in[WIDTH-1];
        w_b_neg    = w_b_signed & rs2_in[WIDTH-1];
        w_a_mag    = w_a_neg ? (~rs1_in + 1'b1) : rs1_in;
        w_b_mag    = w_b_neg ? (~rs2_in + 1'b1) : rs2_in;
        // Remainder follows the dividend; everything else follows the operand sign XOR.
        w_neg_start = (w_is_div && funct3_in[1]) ? w_a_neg : (w_a_neg ^ w_b_neg);
        w_div_zero  = w_is_div && (rs2_in == '0);
        w_div_ovf   = w_is_div && !funct3_in[0] && (rs1_in == {1'b1, {(WIDTH-1){1'b0}}})
                      && (rs2_in == '1);
        if (w_div_zero) begin
            w_special_res = funct3_in[1] ? rs1_in : '1;
        end else begin
            w_special_res = funct3_in[1] ? '0 : rs1_in;
        end
    end

    // One iteration step. Multiply keeps {product_hi, multiplier} in r_acc;
    // divide keeps {remainder, dividend/quotient} in r_acc.
    always_comb begin
        w_sum   = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, (r_acc[0] ? r_opd : '0)};
        w_shift = r_acc[2*WIDTH-1:WIDTH-1];
        w_diff  = w_shift - {1'b0, r_opd};
        if (r_funct3[2]) begin
            if (!w_diff[WIDTH]) begin
                w_acc_nxt = {w_diff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
            end else begin
                w_acc_nxt = {w_shift[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};
            end
        end else begin
            w_acc_nxt = {w_sum, r_acc[WIDTH-1:1]};
        end

        w_prod_s = r_neg ? (~w_acc_nxt + 1'b1) : w_acc_nxt;
        w_quot   = r_neg ? (~w_acc_nxt[WIDTH-1:0] + 1'b1) : w_acc_nxt[WIDTH-1:0];
        w_rem    = r_neg ? (~w_acc_nxt[2*WIDTH-1:WIDTH] + 1'b1) : w_acc_nxt[2*WIDTH-1:WIDTH];

        case (r_funct3)
            3'b000:                 w_final = w_prod_s[WIDTH-1:0];
            3'b001, 3'b010, 3'b011: w_final = w_prod_s[2*WIDTH-1:WIDTH];
            3'b100, 3'b101:         w_final = w_quot;
            default:                w_final = w_rem;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_state  <= S_IDLE;
            r_count  <= '0;
            r_funct3 <= '0;
            r_rd     <= '0;
            r_neg    <= 1'b0;
            r_opd    <= '0;
            r_acc    <= '0;
            r_result <= '0;
        end else if (rdy_in) begin
            case (r_state)
                S_IDLE: begin
                    if (start_in) begin
                        r_funct3 <= funct3_in;
                        r_rd     <= rd_in;
                        r_neg    <= w_neg_start;
                        r_count  <= '0;
                        if (w_div_zero || w_div_ovf) begin
                            r_result <= w_special_res;
                            r_state  <= S_DONE;
                        end else begin
                            r_opd   <= w_is_div ? w_b_mag : w_a_mag;
                            r_acc   <= {{WIDTH{1'b0}}, (w_is_div ? w_a_mag : w_b_mag)};
                            r_state <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    r_acc   <= w_acc_nxt;
                    r_count <= r_count + 1'b1;
                    if (r_count == CW'(WIDTH - 1)) begin
                        r_result <= w_final;
                        r_state  <= S_DONE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
